// File: rtl/centroid_tracker.sv
// Smooths the per-frame centre-of-mass into a tracked position with lock/loss status.
// A frame is judged present from its included-pixel count; updates happen once the divider has settled.
module centroid_tracker #(
  parameter int DIV_LATENCY = 32,
  parameter int MIN_PIXELS  = 64,
  parameter int LOST_FRAMES = 4,
  parameter int SHIFT       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        included,
  input  logic [9:0]  xCenter,
  input  logic [9:0]  yCenter,
  output logic [9:0]  xTrack,
  output logic [9:0]  yTrack,
  output logic [10:0] dx,
  output logic [10:0] dy,
  output logic        frameValid,
  output logic        locked,
  output logic        lost
);

  localparam int CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, UPDATE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cd_q, cd_d;
  logic           fs_cond, fs_cond_q, fs, count_pix, do_update, present;
  logic [19:0]    cnt_q, cnt_d, cnt_l_q, cnt_l_d;
  logic [2:0]     miss_q, miss_d;
  logic [9:0]     trk_q [2];
  logic [9:0]     trk_d [2];
  logic [10:0]    dlt_q [2];
  logic [10:0]    dlt_d [2];
  logic [9:0]     ctr [2];
  logic [9:0]     smooth [2];
  logic           fv_q, fv_d, locked_q, locked_d, lost_q, lost_d;

  // Clearing the registered condition in reset lets a held (0,0) at release still produce an fs.
  assign fs_cond   = (x == 11'd0) && (y == 10'd0);
  assign fs        = fs_cond && !fs_cond_q;
  assign count_pix = included && (x < 11'd1024) && (y < 10'd786);
  assign present   = (cnt_l_q >= 20'(MIN_PIXELS));
  assign ctr[0]    = xCenter;
  assign ctr[1]    = yCenter;

  always_comb begin
    cnt_d   = cnt_q;
    cnt_l_d = cnt_l_q;
    if (fs) begin
      cnt_l_d = cnt_q;
      cnt_d   = {19'd0, count_pix};
    end else if (count_pix && cnt_q != 20'hFFFFF) begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    do_update = 1'b0;
    case (state_q)
      IDLE: begin
        if (fs) begin
          state_d = WAIT;
          cd_d    = CW'(DIV_LATENCY - 1);
        end
      end
      WAIT: begin
        if (fs) begin
          cd_d = CW'(DIV_LATENCY - 1);
        end else if (cd_q == '0) begin
          state_d = UPDATE;
        end else begin
          cd_d = cd_q - 1'b1;
        end
      end
      UPDATE: begin
        do_update = 1'b1;
        if (fs) begin
          state_d = WAIT;
          cd_d    = CW'(DIV_LATENCY - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Exponential smoothing per axis: floor-shifted error, clamped back into the 10-bit range.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      logic signed [11:0] diff, step, sum;
      assign diff = $signed({2'b00, ctr[gi]}) - $signed({2'b00, trk_q[gi]});
      assign step = diff >>> SHIFT;
      assign sum  = $signed({2'b00, trk_q[gi]}) + step;
      assign smooth[gi] = sum[11] ? 10'd0 : ((sum > 12'sd1023) ? 10'd1023 : sum[9:0]);
    end
  endgenerate

  always_comb begin
    trk_d    = trk_q;
    dlt_d    = dlt_q;
    miss_d   = miss_q;
    locked_d = locked_q;
    lost_d   = lost_q;
    fv_d     = 1'b0;
    if (do_update) begin
      fv_d = 1'b1;
      if (present) begin
        miss_d = 3'd0;
        if (!locked_q) begin
          trk_d    = ctr;
          dlt_d[0] = 11'd0;
          dlt_d[1] = 11'd0;
          locked_d = 1'b1;
          lost_d   = 1'b0;
        end else begin
          trk_d    = smooth;
          dlt_d[0] = {1'b0, smooth[0]} - {1'b0, trk_q[0]};
          dlt_d[1] = {1'b0, smooth[1]} - {1'b0, trk_q[1]};
        end
      end else begin
        dlt_d[0] = 11'd0;
        dlt_d[1] = 11'd0;
        miss_d   = (miss_q >= 3'(LOST_FRAMES)) ? 3'(LOST_FRAMES) : miss_q + 3'd1;
        if (miss_d == 3'(LOST_FRAMES)) begin
          locked_d = 1'b0;
          lost_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cd_q      <= '0;
      fs_cond_q <= 1'b0;
      cnt_q     <= 20'd0;
      cnt_l_q   <= 20'd0;
      miss_q    <= 3'd0;
      trk_q[0]  <= 10'd360;
      trk_q[1]  <= 10'd240;
      dlt_q[0]  <= 11'd0;
      dlt_q[1]  <= 11'd0;
      fv_q      <= 1'b0;
      locked_q  <= 1'b0;
      lost_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      fs_cond_q <= fs_cond;
      cnt_q     <= cnt_d;
      cnt_l_q   <= cnt_l_d;
      miss_q    <= miss_d;
      trk_q     <= trk_d;
      dlt_q     <= dlt_d;
      fv_q      <= fv_d;
      locked_q  <= locked_d;
      lost_q    <= lost_d;
    end
  end

  assign xTrack     = trk_q[0];
  assign yTrack     = trk_q[1];
  assign dx         = dlt_q[0];
  assign dy         = dlt_q[1];
  assign frameValid = fv_q;
  assign locked     = locked_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed bench for centroid_tracker: lock-on, smoothing, loss, fs re-trigger, held fs and reset abort.
module tb_centroid_tracker;

  localparam int LAT = 32 + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x;
  logic [9:0]  y;
  logic        included;
  logic [9:0]  xCenter, yCenter;
  logic [9:0]  xTrack, yTrack;
  logic [10:0] dx, dy;
  logic        frameValid, locked, lost;

  int n_checks = 0;
  int n_fails  = 0;

  centroid_tracker dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .included(included),
    .xCenter(xCenter), .yCenter(yCenter), .xTrack(xTrack), .yTrack(yTrack),
    .dx(dx), .dy(dy), .frameValid(frameValid), .locked(locked), .lost(lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      x = 11'(i + 1); y = 10'd10; included = 1'b1;
      tick();
    end
    x = 11'd5; y = 10'd5; included = 1'b0;
  endtask

  task automatic frame_start();
    x = 11'd0; y = 10'd0; included = 1'b0;
    tick();
    x = 11'd5; y = 10'd5;
  endtask

  task automatic wait_pulse(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (frameValid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_track(input string tag, input logic [9:0] ex, input logic [9:0] ey,
                             input logic [10:0] edx, input logic [10:0] edy,
                             input logic elk, input logic elost);
    check({tag, ".xTrack"}, 32'(xTrack), 32'(ex));
    check({tag, ".yTrack"}, 32'(yTrack), 32'(ey));
    check({tag, ".dx"}, 32'(dx), 32'(edx));
    check({tag, ".dy"}, 32'(dy), 32'(edy));
    check({tag, ".locked"}, 32'(locked), 32'(elk));
    check({tag, ".lost"}, 32'(lost), 32'(elost));
  endtask

  initial begin
    int lat, pulses;
    logic [10:0] m25;
    m25 = -11'sd25;
    reset = 1'b1; x = 11'd5; y = 10'd5; included = 1'b0;
    xCenter = 10'd0; yCenter = 10'd0;
    repeat (3) tick();
    check("reset.frameValid", 32'(frameValid), 32'd0);
    check_track("reset", 10'd360, 10'd240, 11'd0, 11'd0, 1'b0, 1'b1);
    reset = 1'b0;
    tick();

    // First present frame locks directly onto the raw centre.
    feed(100);
    xCenter = 10'd500; yCenter = 10'd300;
    frame_start();
    wait_pulse(lat);
    check("acquire.latency", 32'(lat), 32'(LAT));
    check_track("acquire", 10'd500, 10'd300, 11'd0, 11'd0, 1'b1, 1'b0);
    tick();
    check("acquire.pulse_width", 32'(frameValid), 32'd0);

    // Smoothing step with alpha = 1/4.
    feed(100);
    xCenter = 10'd600; yCenter = 10'd200;
    frame_start();
    wait_pulse(lat);
    check("smooth.latency", 32'(lat), 32'(LAT));
    check_track("smooth", 10'd525, 10'd275, 11'd25, m25, 1'b1, 1'b0);

    // Four absent frames: hold, then lose on the fourth.
    for (int f = 1; f <= 4; f++) begin
      feed(10);
      xCenter = 10'd900; yCenter = 10'd900;
      frame_start();
      wait_pulse(lat);
      check($sformatf("miss%0d.latency", f), 32'(lat), 32'(LAT));
      check_track($sformatf("miss%0d", f), 10'd525, 10'd275, 11'd0, 11'd0, (f < 4), (f == 4));
    end
    feed(100);
    xCenter = 10'd100; yCenter = 10'd100;
    frame_start();
    wait_pulse(lat);
    check_track("reacquire", 10'd100, 10'd100, 11'd0, 11'd0, 1'b1, 1'b0);

    // Second fs 10 cycles into WAIT: first frame dropped, second (absent, 9 px) used.
    feed(100);
    xCenter = 10'd700; yCenter = 10'd700;
    frame_start();
    pulses = 0;
    tick();
    if (frameValid) pulses++;
    for (int i = 0; i < 9; i++) begin
      x = 11'(i + 1); y = 10'd10; included = 1'b1;
      tick();
      if (frameValid) pulses++;
    end
    included = 1'b0;
    frame_start();
    wait_pulse(lat);
    check("refs.early_pulses", 32'(pulses), 32'd0);
    check("refs.latency", 32'(lat), 32'(LAT));
    check_track("refs", 10'd100, 10'd100, 11'd0, 11'd0, 1'b1, 1'b0);

    // Frame-start condition held for 5 cycles.
    feed(100);
    xCenter = 10'd200; yCenter = 10'd100;
    x = 11'd0; y = 10'd0; included = 1'b0;
    tick();
    pulses = 0; lat = -1;
    for (int k = 1; k <= 80; k++) begin
      if (k >= 5) begin x = 11'd5; y = 10'd5; end
      tick();
      if (frameValid) begin
        pulses++;
        lat = k;
        check_track("held", 10'd125, 10'd100, 11'd25, 11'd0, 1'b1, 1'b0);
      end
    end
    check("held.pulses", 32'(pulses), 32'd1);
    check("held.latency", 32'(lat), 32'(LAT));

    // Reset inside WAIT aborts; (0,0) present at release gives a fresh fs.
    feed(100);
    xCenter = 10'd50; yCenter = 10'd50;
    frame_start();
    repeat (5) tick();
    reset = 1'b1;
    x = 11'd0; y = 10'd0;
    tick();
    tick();
    check("abort.frameValid", 32'(frameValid), 32'd0);
    check_track("abort", 10'd360, 10'd240, 11'd0, 11'd0, 1'b0, 1'b1);
    reset = 1'b0;
    tick();
    x = 11'd5; y = 10'd5;
    wait_pulse(lat);
    check("release_fs.latency", 32'(lat), 32'(LAT));
    check_track("release_fs", 10'd360, 10'd240, 11'd0, 11'd0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/centroid_tracker.md
CENTROID_TRACKER -- requirements
Module: centroid_tracker

Interface
REQ-001 Parameter DIV_LATENCY, default 32: cycles from frame start until the upstream divider's centre outputs are settled.
REQ-002 Parameter MIN_PIXELS, default 64: minimum included-pixel count for a frame to count as target present.
REQ-003 Parameter LOST_FRAMES, default 4: number of consecutive absent frames that declares the target lost.
REQ-004 Parameter SHIFT, default 2: smoothing factor alpha = 1/2^SHIFT; legal range 0..4.
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 x  input  11  current pixel column, the same timing as the centre-of-mass stage.
REQ-008 y  input  10  current pixel row.
REQ-009 included  input  1  centre-of-mass qualifier for the current pixel.
REQ-010 xCenter  input  10  raw frame centroid X from the centre-of-mass stage.
REQ-011 yCenter  input  10  raw frame centroid Y.
REQ-012 xTrack  output  10  smoothed X.
REQ-013 yTrack  output  10  smoothed Y.
REQ-014 dx  output  11  signed per-frame change of xTrack, two's complement.
REQ-015 dy  output  11  signed per-frame change of yTrack.
REQ-016 frameValid  output  1  one-cycle pulse when the track outputs update.
REQ-017 locked  output  1  target currently tracked.
REQ-018 lost  output  1  target absent for LOST_FRAMES or more frames.

Function
REQ-019 Frame start (fs) shall be the rising edge of (x==0 && y==0), detected with a registered copy of that condition; a held condition shall produce exactly one fs.
REQ-020 The block shall count included pixels with x<1024 and y<786 in a 20-bit counter that saturates at 0xFFFFF; on fs it shall latch the count into cnt_l and restart counting with the fs pixel's own included value.
REQ-021 FSM states: IDLE, WAIT, UPDATE; reset state IDLE.
REQ-022 IDLE->WAIT on fs, loading the countdown with DIV_LATENCY-1.
REQ-023 WAIT decrements the countdown each cycle; at 0 it moves to UPDATE.
REQ-024 An fs during WAIT shall reload the countdown and re-latch cnt_l; the earlier frame is discarded without an update.
REQ-025 UPDATE lasts one cycle, samples xCenter/yCenter, updates the registers, pulses frameValid the next cycle, then returns to IDLE; an fs in UPDATE goes directly to WAIT.
REQ-026 Present frame: cnt_l >= MIN_PIXELS.
REQ-027 Present frame with locked=0: xTrack/yTrack are loaded with the raw centre, dx=dy=0, locked goes to 1, lost goes to 0, and the miss counter clears.
REQ-028 Present frame with locked=1: xTrack += (xCenter - xTrack) >>> SHIFT, using 12-bit signed arithmetic with arithmetic shift (rounding toward negative infinity), clamped to 0..1023; Y is handled identically; dx/dy = new minus old track value; the miss counter clears.
REQ-029 Absent frame: xTrack/yTrack hold, dx=dy=0, and the miss counter (3 bits) increments, saturating at LOST_FRAMES.
REQ-030 When the miss counter reaches LOST_FRAMES: locked goes to 0 and lost goes to 1, both in the same update.
REQ-031 frameValid shall pulse for present and for absent frames.

Reset
REQ-032 When reset is asserted: xTrack=360, yTrack=240, dx=dy=0, frameValid=0, locked=0, lost=1, FSM=IDLE, and all counters are 0.
REQ-033 A reset during WAIT or UPDATE shall abort the pending update, with no frameValid pulse.
REQ-034 The first fs after reset release shall be detected normally, including when x==0 && y==0 is already present as reset deasserts.

Verification
REQ-035 Reset, then a frame with 100 included pixels and a centre of (500,300) -> frameValid exactly DIV_LATENCY+1 cycles after fs; xTrack=500, yTrack=300, locked=1, lost=0, dx=dy=0.
REQ-036 Locked at (500,300), next present frame with a centre of (600,200), SHIFT=2 -> xTrack=525, yTrack=275, dx=+25, dy=-25.
REQ-037 Locked, then 4 frames with 10 included pixels each -> 4 frameValid pulses, track held, locked drops on the 4th pulse with lost=1; the next present frame at (100,100) reloads directly to (100,100).
REQ-038 A second fs 10 cycles into WAIT -> no pulse for the first frame; one pulse DIV_LATENCY+1 cycles after the second fs, using the second count.
REQ-039 x==0 && y==0 held for 5 cycles -> a single fs and a single frameValid pulse.
REQ-040 Reset asserted during WAIT -> no pulse; all outputs at reset values.
